sram_dmem_resp: RTL and testbench
=================================

Name: sram_dmem_resp

Overview:
- Memory-side responder for load/store requests from the core's load-store path.
- Accepts one 32-bit request at a time over a valid/ready handshake and services it as two 16-bit cycles on an external asynchronous SRAM.
- Returns read data or a write acknowledge as a one-cycle response pulse.
- Sits between the LSU data-memory port and the board SRAM pins, replacing the on-chip data memory.

Parameters:
- SRAM_AW, 18, SRAM half-word address width.
- WAIT_CYCLES, 1, extra cycles each SRAM half-access is held, 0..7; each phase lasts WAIT_CYCLES+1 cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high exactly when state is IDLE and rst is high.
- req_addr  input  16  byte address; bits [1:0] ignored.
- req_wren  input  1  1 = store, 0 = load.
- req_bmask  input  4  byte lane enables for stores; bit n enables byte n.
- req_wdata  input  32  store data.
- rsp_valid  output  1  one-cycle response pulse for both loads and stores.
- rsp_rdata  output  32  load data, valid with rsp_valid.
- sram_addr  output  SRAM_AW  half-word address.
- sram_dq_i  input  16  SRAM data in.
- sram_dq_o  output  16  SRAM data out.
- sram_dq_oe  output  1  tristate enable for sram_dq_o.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  output  1 each  active-low SRAM strobes.

Behaviour:
- Reset (rst low at a clock edge):
  - State goes to IDLE; any in-flight access is aborted with no response.
  - All SRAM strobes go to 1 and sram_dq_oe to 0.
  - sram_addr, sram_dq_o, rsp_rdata and rsp_valid go to 0.
  - req_ready is 0 while rst is low.
- States: IDLE, LO, HI, RESP.
- Handshake:
  - A request is accepted on a clock edge where req_valid and req_ready are both 1.
  - On acceptance, latch the word index req_addr[15:2], req_wren, req_bmask and req_wdata, then go to LO.
  - req_valid while busy is ignored; the requester holds the request until accepted.
- Address:
  - sram_addr = {zero-extended word index, half bit}.
  - half bit is 0 in LO and 1 in HI.
- Each phase (LO or HI) lasts WAIT_CYCLES+1 cycles, counted by a phase counter.
- Strobes during a phase:
  - sram_ce_n = 0 throughout.
  - sram_addr is stable throughout.
- Load phases:
  - sram_oe_n = 0, sram_ub_n = 0, sram_lb_n = 0, sram_dq_oe = 0.
  - sram_dq_i is sampled on the last cycle of the phase: LO fills rsp_rdata[15:0], HI fills rsp_rdata[31:16].
- Store phases:
  - sram_oe_n = 1 and sram_dq_oe = 1 throughout.
  - sram_dq_o = wdata[15:0] in LO, wdata[31:16] in HI.
  - sram_we_n = 0 on every cycle of the phase except the last, which gives data hold. With WAIT_CYCLES = 0, sram_we_n = 0 for the single cycle.
  - LO: sram_lb_n = ~bmask[0], sram_ub_n = ~bmask[1].
  - HI: sram_lb_n = ~bmask[2], sram_ub_n = ~bmask[3].
  - If both lanes of a half are disabled, sram_we_n stays 1 for that whole phase.
- Sequencing: LO -> HI -> RESP -> IDLE.
- RESP:
  - rsp_valid = 1 for exactly one cycle; no backpressure.
  - req_ready = 0 during RESP, so the next accept is earliest one cycle after RESP.
- Latency: accept edge T -> rsp_valid at cycle T + 2*(WAIT_CYCLES+1) + 1. With WAIT_CYCLES = 1 this is T+5.
- rsp_rdata holds its last value until the next load completes; stores do not modify it.
- Outside LO/HI, all strobes are 1 and sram_dq_oe = 0.

Optional Feature:
- Macro: SRAM_HALF_SKIP_EN.
- When defined:
  - A store whose LO lanes (bmask[1:0]) are both 0 skips LO and goes straight to HI.
  - A store whose HI lanes (bmask[3:2]) are both 0 goes from LO to RESP.
  - A store with bmask = 0 goes from accept directly to RESP, so rsp_valid appears the cycle after the accept edge.
  - Loads are unaffected.
- When undefined: both phases always run with full timing, and masked halves keep sram_we_n = 1.

Test Plan:
- Reset, then store: rst low 2 cycles, release; store addr 0x0010, wdata 0xDEADBEEF, bmask 0xF.
  - sram_addr = 8 then 9; dq_o = 0xBEEF then 0xDEAD.
  - we_n low 1 cycle per phase (WAIT_CYCLES=1).
  - rsp_valid at T+5.
- Load: SRAM model holds 0x1234 at addr 8 and 0x5678 at addr 9; load addr 0x0010 -> rsp_rdata = 0x56781234 at T+5, oe_n low across both phases.
- Byte store: bmask 0x4, addr 0x0020, wdata 0x00AB0000.
  - LO: we_n stays 1.
  - HI: lb_n = 0, ub_n = 1, dq_o = 0x00AB.
  - With SRAM_HALF_SKIP_EN: LO skipped and rsp_valid at T+3.
- Back-to-back: req_valid held high with two loads -> second accepted exactly one cycle after the first rsp_valid; req_ready low throughout.
- Reset mid-access: rst low during the HI phase of a store -> next edge all strobes 1, dq_oe 0, no rsp_valid; req_ready returns to 1 after release.
- WAIT_CYCLES = 0, load -> each phase 1 cycle, rsp_valid at T+3.

Source files
------------

// File: rtl/sram_dmem_resp_if.sv
// sram_dmem_resp_if: LSU-side request/response bus of the SRAM data-memory responder.
interface sram_dmem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_wren;
    logic [3:0]  req_bmask;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    modport master (output req_valid, req_addr, req_wren, req_bmask, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_addr, req_wren, req_bmask, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/sram_dmem_resp.sv
// sram_dmem_resp: serves 32-bit LSU loads/stores as two 16-bit async SRAM half-accesses.
// Optional SRAM_HALF_SKIP_EN skips store halves whose byte lanes are all disabled.
module sram_dmem_resp #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    sram_dmem_resp_if.slave    bus,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_dq_i,
    output logic [15:0]        sram_dq_o,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_e;
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [13:0] idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [3:0]  bm_q, bm_d;
    logic [31:0] wd_q, wd_d, rd_q, rd_d;
    logic        act, hi, last, accept;
    logic [1:0]  lanes;
    logic        skip_lo_in, skip_hi_in, skip_hi_q;
`ifdef SRAM_HALF_SKIP_EN
    assign skip_lo_in = bus.req_wren && bus.req_bmask[1:0] == 2'b00;
    assign skip_hi_in = bus.req_wren && bus.req_bmask[3:2] == 2'b00;
    assign skip_hi_q  = wr_q && bm_q[3:2] == 2'b00;
`else
    assign skip_lo_in = 1'b0;
    assign skip_hi_in = 1'b0;
    assign skip_hi_q  = 1'b0;
`endif
    always_comb begin
        act           = state_q == LO || state_q == HI;
        hi            = state_q == HI;
        last          = cnt_q == 3'(WAIT_CYCLES);
        lanes         = hi ? bm_q[3:2] : bm_q[1:0];
        bus.req_ready = state_q == IDLE && rst;
        bus.rsp_valid = state_q == RESP;
        bus.rsp_rdata = rd_q;
        accept        = bus.req_valid && bus.req_ready;
        sram_addr     = {{(SRAM_AW-15){1'b0}}, idx_q, hi};
        sram_dq_o     = hi ? wd_q[31:16] : wd_q[15:0];
        sram_dq_oe    = act && wr_q;
        sram_ce_n     = !act;
        sram_oe_n     = !(act && !wr_q);
        // the final cycle of a store phase releases we_n so data is held past the write edge
        sram_we_n     = !(act && wr_q && |lanes && (WAIT_CYCLES == 0 || !last));
        sram_lb_n     = !(act && (!wr_q || lanes[0]));
        sram_ub_n     = !(act && (!wr_q || lanes[1]));
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        wr_d          = wr_q;
        bm_d          = bm_q;
        wd_d          = wd_q;
        rd_d          = rd_q;
        if (accept) begin
            idx_d   = bus.req_addr[15:2];
            wr_d    = bus.req_wren;
            bm_d    = bus.req_bmask;
            wd_d    = bus.req_wdata;
            cnt_d   = 3'd0;
            state_d = skip_lo_in ? (skip_hi_in ? RESP : HI) : LO;
        end
        if (act) begin
            cnt_d   = last ? 3'd0 : cnt_q + 3'd1;
            state_d = last ? ((hi || skip_hi_q) ? RESP : HI) : state_q;
            if (last && !wr_q)
                rd_d = hi ? {sram_dq_i, rd_q[15:0]} : {rd_q[31:16], sram_dq_i};
        end
        if (state_q == RESP)
            state_d = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= 14'd0;
            wr_q    <= 1'b0;
            bm_q    <= 4'd0;
            wd_q    <= 32'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            bm_q    <= bm_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: tb/tb_sram_dmem_resp.sv
// tb_sram_dmem_resp: directed and random checks of sram_dmem_resp against a word-level memory model.
module tb_sram_dmem_resp;
    localparam int W = 1;
`ifdef SRAM_HALF_SKIP_EN
    localparam int BHO = 0;
`else
    localparam int BHO = 2;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sram_dmem_resp_if bus ();
    sram_dmem_resp_if bus0 ();
    logic [17:0] a, a0;
    logic [15:0] dqi, dqo, dqi0, dqo0;
    logic dqoe, ce_n, oe_n, we_n, ub_n, lb_n;
    logic dqoe0, ce0, oe0, we0, ub0, lb0;

    sram_dmem_resp #(.SRAM_AW(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .sram_addr(a), .sram_dq_i(dqi), .sram_dq_o(dqo),
        .sram_dq_oe(dqoe), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
        .sram_ub_n(ub_n), .sram_lb_n(lb_n));
    sram_dmem_resp #(.SRAM_AW(18), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .sram_addr(a0), .sram_dq_i(dqi0), .sram_dq_o(dqo0),
        .sram_dq_oe(dqoe0), .sram_ce_n(ce0), .sram_oe_n(oe0), .sram_we_n(we0),
        .sram_ub_n(ub0), .sram_lb_n(lb0));

    // Behavioural async SRAM; only the main DUT writes it, preload port seeds contents
    logic [15:0] mem [0:511];
    logic        pre_en = 1'b0;
    logic [8:0]  pre_a = '0;
    logic [15:0] pre_d = '0;
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (!ce_n && !we_n) begin
            if (!lb_n) mem[a[8:0]][7:0]  <= dqo[7:0];
            if (!ub_n) mem[a[8:0]][15:8] <= dqo[15:8];
        end
    end
    assign dqi  = (!ce_n && !oe_n) ? mem[a[8:0]]  : 16'hBAD0;
    assign dqi0 = (!ce0 && !oe0)   ? mem[a0[8:0]] : 16'hBAD0;

    int checks = 0, failures = 0;
    int lat, wt;
    logic [17:0] t_addr [1:40];
    logic [15:0] t_dq   [1:40];
    logic [5:0]  t_str  [1:40];
    logic        t_rdy  [1:40];
    logic [31:0] ref_w  [0:255];
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] bm);
        logic [31:0] r = old;
        for (int n = 0; n < 4; n++) if (bm[n]) r[8*n +: 8] = wd[8*n +: 8];
        return r;
    endfunction

    function automatic int exp_lat(input logic wr, input logic [3:0] bm);
`ifdef SRAM_HALF_SKIP_EN
        if (wr) return (int'(|bm[1:0]) + int'(|bm[3:2])) * (W + 1) + 1;
`endif
        return 2 * (W + 1) + 1;
    endfunction

    task automatic preload(input logic [8:0] ha, input logic [15:0] d);
        pre_en = 1'b1; pre_a = ha; pre_d = d;
        ref_w[ha[8:1]][16*ha[0] +: 16] = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Trace index c=1 is the cycle right after the accept edge; lat is the c holding rsp_valid
    task automatic issue(input logic wr, input logic [15:0] ad, input logic [3:0] bm, input logic [31:0] wd);
        bus.req_valid = 1'b1; bus.req_wren = wr; bus.req_addr = ad;
        bus.req_bmask = bm; bus.req_wdata = wd;
        wt = 0;
        while (!bus.req_ready && wt < 50) begin @(posedge clk); #1; wt++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            t_addr[c] = a; t_dq[c] = dqo; t_rdy[c] = bus.req_ready;
            t_str[c] = {ce_n, oe_n, we_n, ub_n, lb_n, dqoe};
            if (bus.rsp_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        if (wr) ref_w[ad[9:2]] = merge(ref_w[ad[9:2]], wd, bm);
    endtask

    initial begin
        logic any;
        logic wr;
        logic [3:0] bm;
        logic [31:0] wd;
        int w;
        bus.req_valid = 1'b0; bus.req_wren = 1'b0; bus.req_addr = '0; bus.req_bmask = '0; bus.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_wren = 1'b0; bus0.req_addr = '0; bus0.req_bmask = '0; bus0.req_wdata = '0;
        for (int i = 0; i < 256; i++) ref_w[i] = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_strobes", {26'd0, ce_n, oe_n, we_n, ub_n, lb_n, dqoe}, 32'b111110);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_addr", a, 0);
        chk("rst_dq_o", dqo, 0);
        chk("rst_ready0", bus0.req_ready, 0);
        rst = 1'b1;
        #1 chk("ready_after_rst", bus.req_ready, 1);
        for (int i = 0; i < 64; i++) preload(9'(i), 16'($urandom));

        issue(1'b1, 16'h0010, 4'hF, 32'hDEADBEEF);
        chk("st_lat", lat, 5);
        chk("st_addr_lo", t_addr[1], 8);
        chk("st_addr_lo2", t_addr[2], 8);
        chk("st_addr_hi", t_addr[3], 9);
        chk("st_dq_lo", t_dq[1], 16'hBEEF);
        chk("st_dq_hi", t_dq[3], 16'hDEAD);
        chk("st_str_c1", t_str[1], 6'b010001);
        chk("st_str_c2", t_str[2], 6'b011001);
        chk("st_str_c3", t_str[3], 6'b010001);
        chk("st_str_c4", t_str[4], 6'b011001);
        chk("st_str_resp", t_str[5], 6'b111110);
        chk("st_mem", {mem[9], mem[8]}, 32'hDEADBEEF);

        preload(9'd8, 16'h1234);
        preload(9'd9, 16'h5678);
        issue(1'b0, 16'h0010, 4'h0, 32'h0);
        chk("ld_lat", lat, 5);
        chk("ld_rdata", bus.rsp_rdata, 32'h56781234);
        chk("ld_str", {t_str[1], t_str[2], t_str[3], t_str[4]}, {4{6'b001000}});
        last_rd = 32'h56781234;

        bus0.req_valid = 1'b1; bus0.req_addr = 16'h0010;
        wt = 0;
        while (!bus0.req_ready && wt < 50) begin @(posedge clk); #1; wt++; end
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus0.rsp_valid) begin lat = c; break; end
            @(posedge clk); #1;
        end
        chk("w0_lat", lat, 3);
        chk("w0_rdata", bus0.rsp_rdata, 32'h56781234);

        issue(1'b1, 16'h0020, 4'h4, 32'h00AB0000);
        chk("bs_lat", lat, exp_lat(1'b1, 4'h4));
`ifndef SRAM_HALF_SKIP_EN
        chk("bs_lo_str", {t_str[1], t_str[2]}, {2{6'b011111}});
`endif
        chk("bs_hi_str", {t_str[BHO+1], t_str[BHO+2]}, {6'b010101, 6'b011101});
        chk("bs_hi_dq", t_dq[BHO+1], 16'h00AB);
        chk("bs_hi_addr", t_addr[BHO+1], 17);
        chk("bs_rd_hold", bus.rsp_rdata, last_rd);
        chk("bs_mem", {mem[17], mem[16]}, ref_w[8]);

        issue(1'b0, 16'h0010, 4'h0, 32'h0);
        chk("b2b_rd1", bus.rsp_rdata, ref_w[4]);
        any = 1'b0;
        for (int c = 1; c <= lat; c++) any |= t_rdy[c];
        chk("b2b_ready_low", any, 0);
        issue(1'b0, 16'h0020, 4'h0, 32'h0);
        chk("b2b_gap", wt, 1);
        chk("b2b_rd2", bus.rsp_rdata, ref_w[8]);

        bus.req_valid = 1'b1; bus.req_wren = 1'b1; bus.req_addr = 16'h0100;
        bus.req_bmask = 4'hF; bus.req_wdata = 32'hCAFEF00D;
        wt = 0;
        while (!bus.req_ready && wt < 50) begin @(posedge clk); #1; wt++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_in_hi", a, 18'h81);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_strobes", {ce_n, oe_n, we_n, ub_n, lb_n, dqoe}, 6'b111110);
        chk("mid_rsp", bus.rsp_valid, 0);
        chk("mid_ready", bus.req_ready, 0);
        chk("mid_rdata", bus.rsp_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1 chk("mid_ready_back", bus.req_ready, 1);
        any = 1'b0;
        for (int c = 0; c < 6; c++) begin @(posedge clk); #1; any |= bus.rsp_valid; end
        chk("mid_no_rsp", any, 0);
        last_rd = 32'h0;

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 31);
            bm = 4'($urandom);
            wd = $urandom;
            for (int g = $urandom_range(0, 2); g > 0; g--) begin @(posedge clk); #1; end
            issue(wr, 16'(w * 4), bm, wd);
            chk("rnd_lat", lat, exp_lat(wr, bm));
            if (!wr) begin
                chk("rnd_load", bus.rsp_rdata, ref_w[w]);
                last_rd = ref_w[w];
            end else
                chk("rnd_store_hold", bus.rsp_rdata, last_rd);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) chk("final_mem", {mem[2*i+1], mem[2*i]}, ref_w[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
